afg_phase_seq: RTL and testbench
================================

# afg_phase_seq

Sequencer for the arbitrary function generator's pipelined phase accumulator, built from a chain of 2-bit period-accumulator slices with registered carries. The block owns the tuning word and produces skewed per-slice enables and skewed per-slice addend bits so the carry pipeline stays aligned. It runs a start/fill/run/drain state machine, accepts new frequency tuning words (FTW) through a valid/ready handshake, and reports phase validity and period wraps to the waveform lookup stage.

## Interface
- NSLICE, 8, number of 2-bit slices; phase width W = 2*NSLICE; legal range 2..16
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low
- ftw_data  in  W  new tuning word
- ftw_valid  in  1  ftw_data valid
- ftw_ready  out  1  block can accept a tuning word this cycle
- start  in  1  level sampled per cycle; begin accumulation
- stop  in  1  level sampled per cycle; end accumulation
- top_cout  in  1  registered cout of slice NSLICE-1
- slice_en  out  NSLICE  EN to slice k on bit k
- slice_a  out  W  in_a to slice k on bits [2k+1:2k]
- phase_valid  out  1  all slices enabled and aligned
- busy  out  1  state != IDLE
- wrap  out  1  one-cycle pulse per phase wrap

## Operation
- FSM states: IDLE, FILL, RUN, DRAIN.
- IDLE:
  - ftw_ready=1.
  - start=1 and stop=0 -> FILL, setting slice_en[0] at the same edge.
  - start and stop both 1 -> stay in IDLE; stop has priority.
- FILL:
  - slice_en[k] rises k edges after slice_en[0], via a shift of the enable front.
  - After NSLICE-1 cycles -> RUN.
  - ftw_ready=0.
  - stop=1 -> DRAIN immediately, draining only the slices already enabled.
- RUN:
  - ftw_ready=1.
  - phase_valid=1.
  - stop=1 -> DRAIN.
  - start is ignored.
- DRAIN:
  - slice_en[0] clears first; the clear front ripples one slice per cycle.
  - When slice_en is all zero -> IDLE. This takes at most NSLICE-1 cycles after slice_en[0] clears.
  - ftw_ready=0.
  - start is ignored.
- FTW handshake:
  - Transfer occurs on the edge where ftw_valid and ftw_ready are both 1.
  - The word loads the active FTW register, which drives skew stage 0.
  - Skew: slice_a bits for slice k = active FTW bits [2k+1:2k], delayed k cycles through a triangular register array.
  - A word accepted in RUN therefore propagates glitch-free through the carry pipeline.
- wrap = top_cout AND phase_valid, registered.
- Slice accumulation is mod 4 per slice. Whole-phase wrap is mod 2^W. No saturation.
- Reset (Reset=0 at any edge, including mid-FILL, RUN or DRAIN), all at that edge:
  - state=IDLE
  - slice_en=0
  - slice_a=0
  - active FTW=0
  - phase_valid=0
  - wrap=0
  - busy=0
  - ftw_ready=0 for that cycle, then 1.

## Timing
- start sampled at edge E0 -> slice_en[0]=1 after E0; slice_en[k]=1 after E0+k.
- phase_valid=1 after E0+NSLICE-1.
- stop sampled at edge S0 in RUN:
  - phase_valid=0 after S0.
  - slice_en[k]=0 after S0+k.
  - busy=0 after S0+NSLICE-1.
- FTW accepted at edge F0 -> slice_a slice k field updates after F0+1+k.
- wrap asserts one cycle after top_cout is 1 with phase_valid=1.
- The minimum start-to-start cycle is 2*NSLICE cycles.

## Configuration
- AFG_BURST_EN defined:
  - Adds input burst_len (16 bits) and output done (1-bit pulse).
  - A wrap counter clears on entry to FILL and increments on each wrap.
  - When count == burst_len and burst_len != 0, an internal stop is generated: DRAIN next edge, done=1 for one cycle.
  - burst_len=0 means continuous running.
  - done resets to 0.
- AFG_BURST_EN undefined:
  - No burst_len, done or counter.
  - Only the external stop ends a run.

## Test plan
- Reset mid-RUN (NSLICE=8), Reset=0 for 1 cycle -> next cycle slice_en=0x00, slice_a=0, phase_valid=0, busy=0; ftw_ready=1 one cycle later.
- FTW=0x0100 loaded in IDLE, start pulse -> slice_en goes 0x01,0x03,…,0xFF over 8 cycles; phase_valid rises 7 cycles after start; wrap pulses every 256 cycles.
- FTW change 0x0100 -> 0x0400 in RUN -> slice_a field k updates at F0+1+k; no ftw_ready drop; wrap period becomes 64 cycles.
- start=stop=1 in IDLE -> stays IDLE, slice_en=0. stop 3 cycles into FILL -> slice_en peaks at 0x0F, then clears LSB-first; busy drops when all clear.
- ftw_valid held high during FILL and DRAIN -> no transfer (ftw_ready=0); the word transfers on the first RUN cycle.
- AFG_BURST_EN, burst_len=3, FTW=0x4000 -> exactly 3 wrap pulses, done pulses with the third-wrap-triggered stop, busy=0 NSLICE-1 cycles later.

Source files
------------

// File: rtl/afg_phase_seq.sv
// Start/fill/run/drain sequencer for the pipelined 2-bit-slice phase accumulator.
// Optional burst mode (runs end after burst_len wraps) is enabled by defining AFG_BURST_EN.
module afg_phase_seq #(
    parameter int NSLICE = 8,
    localparam int W = 2 * NSLICE
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [W-1:0]      ftw_data,
    input  logic              ftw_valid,
    output logic              ftw_ready,
    input  logic              start,
    input  logic              stop,
    input  logic              top_cout,
`ifdef AFG_BURST_EN
    input  logic [15:0]       burst_len,
    output logic              done,
`endif
    output logic [NSLICE-1:0] slice_en,
    output logic [W-1:0]      slice_a,
    output logic              phase_valid,
    output logic              busy,
    output logic              wrap
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [NSLICE-1:0] en_q, en_d;
    logic [NSLICE-1:0] fillEn, drainEn;
    logic [W-1:0]      ftw_q, ftw_d;
    logic              rstHold_q;
    logic              wrap_q;
    logic              stopReq;
    logic              burstHit;

    assign fillEn  = {en_q[NSLICE-2:0], 1'b1};
    // The clear front only removes slices that are on, so a stop mid-fill never enables new ones.
    assign drainEn = en_q & {en_q[NSLICE-2:0], 1'b0};
    assign stopReq = stop | burstHit;

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = FILL;
                    en_d    = {{(NSLICE-1){1'b0}}, 1'b1};
                end
            end
            FILL: begin
                if (stopReq) begin
                    en_d    = drainEn;
                    state_d = (drainEn == '0) ? IDLE : DRAIN;
                end else begin
                    en_d = fillEn;
                    if (&fillEn) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stopReq) begin
                    en_d    = drainEn;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                en_d = drainEn;
                if (drainEn == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
            end
        endcase
    end

    // Ready is held low for the cycle following a reset edge.
    assign ftw_ready   = !rstHold_q && ((state_q == IDLE) || (state_q == RUN));
    assign ftw_d       = (ftw_valid && ftw_ready) ? ftw_data : ftw_q;
    assign phase_valid = (state_q == RUN);
    assign busy        = (state_q != IDLE);
    assign slice_en    = en_q;
    assign wrap        = wrap_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            en_q      <= '0;
            ftw_q     <= '0;
            rstHold_q <= 1'b1;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            ftw_q     <= ftw_d;
            rstHold_q <= 1'b0;
            wrap_q    <= top_cout & phase_valid;
        end
    end

    // Slice k sees its addend field k+1 cycles after the active word, matching the carry skew.
    for (genvar k = 0; k < NSLICE; k++) begin : gSkew
        logic [1:0] stage_q [k+1];

        always_ff @(posedge Clock) begin
            if (!Reset) begin
                for (int j = 0; j <= k; j++) begin
                    stage_q[j] <= 2'b00;
                end
            end else begin
                stage_q[0] <= ftw_q[2*k +: 2];
                for (int j = 1; j <= k; j++) begin
                    stage_q[j] <= stage_q[j-1];
                end
            end
        end

        assign slice_a[2*k +: 2] = stage_q[k];
    end

`ifdef AFG_BURST_EN
    logic [15:0] wrapCnt_q, wrapCnt_d;
    logic        done_q;

    assign burstHit = (state_q == RUN) && (burst_len != 16'd0) && (wrapCnt_q == burst_len);
    assign done     = done_q;

    always_comb begin
        wrapCnt_d = wrapCnt_q;
        if ((state_q == IDLE) && (state_d == FILL)) begin
            wrapCnt_d = 16'd0;
        end else if (wrap_q) begin
            wrapCnt_d = wrapCnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wrapCnt_q <= 16'd0;
            done_q    <= 1'b0;
        end else begin
            wrapCnt_q <= wrapCnt_d;
            done_q    <= burstHit;
        end
    end
`else
    assign burstHit = 1'b0;
`endif

endmodule

// File: tb/tb_afg_phase_seq.sv
// Self-checking bench for afg_phase_seq: slice-count model plus a 2-bit slice chain harness.
// Burst checks are compiled in when AFG_BURST_EN is defined.
module tb_afg_phase_seq;

    localparam int N = 8;
    localparam int W = 2 * N;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic [W-1:0] ftw_data = '0;
    logic         ftw_valid = 1'b0;
    logic         ftw_ready;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         top_cout;
    logic [N-1:0] slice_en;
    logic [W-1:0] slice_a;
    logic         phase_valid;
    logic         busy;
    logic         wrap;
    logic [15:0]  burstLen = 16'd0;
`ifdef AFG_BURST_EN
    logic         done;
`endif

    int  passCount = 0;
    int  checkCount = 0;
    int  cycle = 0;
    logic cmpEn = 1'b0;

    always #5 Clock = ~Clock;

    afg_phase_seq #(.NSLICE(N)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ftw_data    (ftw_data),
        .ftw_valid   (ftw_valid),
        .ftw_ready   (ftw_ready),
        .start       (start),
        .stop        (stop),
        .top_cout    (top_cout),
`ifdef AFG_BURST_EN
        .burst_len   (burstLen),
        .done        (done),
`endif
        .slice_en    (slice_en),
        .slice_a     (slice_a),
        .phase_valid (phase_valid),
        .busy        (busy),
        .wrap        (wrap)
    );

    // Model: mOn slices have been switched on from the bottom, mOff of them switched off again.
    int          mOn = 0;
    int          mOff = 0;
    logic        mDrain = 1'b0;
    logic        mHold = 1'b1;
    logic        mWrap = 1'b0;
    logic        mDone = 1'b0;
    logic [15:0] mCount = 16'd0;
    logic [W-1:0] mHist [0:N];

    logic [N-1:0] expEn;
    logic [W-1:0] expA;
    logic         expValid, expReady, expBusy;

    always_comb begin
        expEn = '0;
        expA  = '0;
        for (int k = 0; k < N; k++) begin
            expEn[k]       = (k >= mOff) && (k < mOn);
            expA[2*k +: 2] = mHist[k+1][2*k +: 2];
        end
        expValid = (mOn == N) && !mDrain;
        expReady = !mHold && ((mOn == 0) || expValid);
        expBusy  = (mOn != 0);
    end

    always @(posedge Clock) begin : modelUpdate
        int on, off;
        logic dr, hit;
        logic [W-1:0] nextFtw;
        if (!Reset) begin
            mOn <= 0;
            mOff <= 0;
            mDrain <= 1'b0;
            mHold <= 1'b1;
            mWrap <= 1'b0;
            mDone <= 1'b0;
            mCount <= 16'd0;
            for (int i = 0; i <= N; i++) mHist[i] <= '0;
        end else begin
            on = mOn;
            off = mOff;
            dr = mDrain;
            hit = expValid && (burstLen != 16'd0) && (mCount == burstLen);
            if (on == 0) begin
                if (start && !stop) on = 1;
            end else if (dr) begin
                off = off + 1;
            end else if (stop || hit) begin
                dr = 1'b1;
                off = 1;
            end else if (on < N) begin
                on = on + 1;
            end
            if (on != 0 && off >= on) begin
                on = 0;
                off = 0;
                dr = 1'b0;
            end
            nextFtw = (ftw_valid && expReady) ? ftw_data : mHist[0];
            mOn <= on;
            mOff <= off;
            mDrain <= dr;
            mHold <= 1'b0;
            mWrap <= top_cout && expValid;
            mDone <= hit;
            mCount <= (mOn == 0 && on == 1) ? 16'd0 : (mWrap ? mCount + 16'd1 : mCount);
            mHist[0] <= nextFtw;
            for (int i = 1; i <= N; i++) mHist[i] <= mHist[i-1];
        end
    end

    // Slice chain driven from the model's enables and addends; supplies top_cout.
    logic [1:0]   hAcc [N];
    logic [N-1:0] hCout = '0;
    logic [N-1:0] hCin;
    assign hCin     = {hCout[N-2:0], 1'b0};
    assign top_cout = hCout[N-1];

    function automatic logic [2:0] sliceSum(input logic [1:0] acc, input logic [1:0] a, input logic cin);
        return {1'b0, acc} + {1'b0, a} + {2'b00, cin};
    endfunction

    always @(posedge Clock) begin
        for (int k = 0; k < N; k++) begin
            if (!Reset) begin
                hAcc[k]  <= 2'b00;
                hCout[k] <= 1'b0;
            end else if (expEn[k]) begin
                {hCout[k], hAcc[k]} <= sliceSum(hAcc[k], expA[2*k +: 2], hCin[k]);
            end else begin
                hCout[k] <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    endtask

    always @(negedge Clock) begin
        if (cmpEn) begin
            checkOutput("slice_en", slice_en, expEn);
            checkOutput("slice_a", slice_a, expA);
            checkOutput("phase_valid", phase_valid, expValid);
            checkOutput("busy", busy, expBusy);
            checkOutput("ftw_ready", ftw_ready, expReady);
            checkOutput("wrap", wrap, mWrap);
`ifdef AFG_BURST_EN
            checkOutput("done", done, mDone);
`endif
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic v, input logic [W-1:0] d);
        start = st;
        stop = sp;
        ftw_valid = v;
        ftw_data = d;
        step();
    endtask

    task automatic waitWrap(input int budget, output int at);
        int n = 0;
        while (wrap !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (wrap !== 1'b1) checkOutput("wrap_timeout", wrap, 1);
        at = cycle;
        step();
    endtask

    initial begin
        int t1, t2, t3;
        int wraps;
        step();
        step();
        cmpEn = 1'b1;
        checkOutput("reset_slice_en", slice_en, 8'h00);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ftw_ready", ftw_ready, 0);
        Reset = 1'b1;
        step();
        checkOutput("post_reset_ready", ftw_ready, 1);

        // start and stop together in IDLE: stop wins
        applyStimulus(1, 1, 0, 16'h0000);
        checkOutput("start_stop_busy", busy, 0);
        checkOutput("start_stop_en", slice_en, 8'h00);

        // FTW 0x0100 then fill
        applyStimulus(0, 0, 1, 16'h0100);
        applyStimulus(1, 0, 0, 16'h0100);
        checkOutput("fill_en0", slice_en, 8'h01);
        for (int k = 1; k < N; k++) begin
            applyStimulus(0, 0, 0, 16'h0100);
            checkOutput("fill_en", slice_en, (64'd1 << (k + 1)) - 1);
            if (k == N - 2) checkOutput("fill_pv_low", phase_valid, 0);
        end
        checkOutput("fill_pv_high", phase_valid, 1);

        waitWrap(400, t1);
        waitWrap(300, t2);
        waitWrap(300, t3);
        checkOutput("wrap_period_256a", t2 - t1, 256);
        checkOutput("wrap_period_256b", t3 - t2, 256);

        // retune in RUN
        applyStimulus(0, 0, 1, 16'h0400);
        checkOutput("retune_ready", ftw_ready, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 16'h0400);
        checkOutput("skew_f4", slice_a, 16'h0100);
        step();
        checkOutput("skew_f5", slice_a, 16'h0000);
        step();
        checkOutput("skew_f6", slice_a, 16'h0400);
        for (int i = 0; i < 20; i++) step();
        waitWrap(300, t1);
        waitWrap(100, t2);
        waitWrap(100, t3);
        checkOutput("wrap_period_64a", t2 - t1, 64);
        checkOutput("wrap_period_64b", t3 - t2, 64);

        // stop from RUN
        applyStimulus(0, 1, 0, 16'h0400);
        checkOutput("stop_pv", phase_valid, 0);
        checkOutput("stop_en", slice_en, 8'hFE);
        for (int i = 0; i < N - 2; i++) applyStimulus(0, 0, 0, 16'h0400);
        checkOutput("drain_busy_s6", busy, 1);
        step();
        checkOutput("drain_busy_s7", busy, 0);
        checkOutput("drain_en_s7", slice_en, 8'h00);

        // ftw_valid held through FILL; transfer on first RUN cycle
        applyStimulus(1, 0, 0, 16'h0800);
        for (int i = 0; i < N - 2; i++) applyStimulus(0, 0, 1, 16'h0800);
        checkOutput("fill_ready_low", ftw_ready, 0);
        applyStimulus(0, 0, 1, 16'h0800);
        checkOutput("run_ready_high", ftw_ready, 1);
        applyStimulus(0, 0, 1, 16'h0800);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 16'h0800);
        checkOutput("held_ftw_f5", slice_a, 16'h0400);
        step();
        checkOutput("held_ftw_f6", slice_a, 16'h0800);

        // ftw_valid held through DRAIN
        applyStimulus(0, 1, 1, 16'h1234);
        checkOutput("drain_ready_low", ftw_ready, 0);
        for (int i = 0; i < N - 1; i++) applyStimulus(0, 0, 1, 16'h1234);
        checkOutput("drain_done_ready", ftw_ready, 1);
        applyStimulus(0, 0, 1, 16'h1234);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 16'h1234);
        checkOutput("idle_ftw_skewed", slice_a, 16'h1234);

        // reset mid-RUN
        applyStimulus(1, 0, 0, 16'h0000);
        for (int i = 0; i < 10; i++) step();
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("rst_en", slice_en, 8'h00);
        checkOutput("rst_a", slice_a, 16'h0000);
        checkOutput("rst_pv", phase_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", ftw_ready, 0);
        Reset = 1'b1;
        step();
        checkOutput("rst_ready_after", ftw_ready, 1);

        // stop during FILL at 0x0F
        applyStimulus(1, 0, 0, 16'h0000);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("peak_en", slice_en, 8'h0F);
        applyStimulus(0, 1, 0, 16'h0000);
        checkOutput("fdrain_en1", slice_en, 8'h0E);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("fdrain_en2", slice_en, 8'h0C);
        step();
        checkOutput("fdrain_en3", slice_en, 8'h08);
        checkOutput("fdrain_busy3", busy, 1);
        step();
        checkOutput("fdrain_en4", slice_en, 8'h00);
        checkOutput("fdrain_busy4", busy, 0);

`ifdef AFG_BURST_EN
        burstLen = 16'd3;
        wraps = 0;
        applyStimulus(0, 0, 1, 16'h4000);
        applyStimulus(1, 0, 0, 16'h4000);
        for (int i = 0; i < 200; i++) begin
            if (wrap === 1'b1) wraps++;
            if (done === 1'b1) break;
            step();
        end
        checkOutput("burst_done", done, 1);
        checkOutput("burst_wraps", wraps, 3);
        for (int i = 0; i < N - 2; i++) step();
        checkOutput("burst_busy_hold", busy, 1);
        step();
        checkOutput("burst_busy_drop", busy, 0);
        burstLen = 16'd0;
`else
        wraps = 0;
`endif

        step();
        step();
        cmpEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
